// File: rtl/fu_issue_fifo.sv
// Per-FU-class issue queue: accepts up to three matching RS issue slots per cycle,
// buffers them in order and hands one packet per cycle to the functional unit.
package fu_issue_pkg;

  typedef enum logic [1:0] {
    ALU_1  = 2'd0,
    LS_1   = 2'd1,
    MULT_1 = 2'd2,
    BRANCH = 2'd3
  } fu_sel_t;

  typedef struct packed {
    logic        valid;
    fu_sel_t     fu_sel;
    logic [31:0] PC;
    logic [31:0] inst;
    logic [4:0]  rob_idx;
  } RS_S_PACKET;

endpackage

module fu_issue_fifo
  import fu_issue_pkg::*;
#(
  parameter fu_sel_t FU_TYPE = ALU_1,
  parameter int      DEPTH   = 8,
  parameter int      PTR_W   = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  RS_S_PACKET           issue_insts [2:0],
  input  logic                 fu_ready,
  output RS_S_PACKET           fu_packet,
  output logic                 fu_valid,
  output logic                 stall,
  output logic [PTR_W:0]       count,
  output logic                 overflow_err
);

  localparam logic [PTR_W:0]   DEPTH_C = DEPTH[PTR_W:0];
  localparam logic [PTR_W+1:0] DEPTH_X = DEPTH[PTR_W+1:0];

  RS_S_PACKET       entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [2:0]       acc;
  logic             pop;
  logic [PTR_W+1:0] space;
  logic [PTR_W+1:0] nwr;
  logic [2:0]       wr_en;
  logic [PTR_W-1:0] wr_ptr [3];
  logic             drop;
  logic [PTR_W:0]   free_slots;

  function automatic logic [PTR_W:0] next_count(input logic [PTR_W:0] cur,
                                                input logic [PTR_W+1:0] pushed,
                                                input logic popped);
    return cur + pushed[PTR_W:0] - {{PTR_W{1'b0}}, popped};
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      acc[k] = issue_insts[k].valid && (issue_insts[k].fu_sel == FU_TYPE);
    end
  end

  assign fu_valid   = (count != '0);
  assign pop        = fu_valid && fu_ready;
  assign fu_packet  = fu_valid ? entries[head] : '0;
  assign free_slots = DEPTH_C - count;
  // Registered count only: whatever the RS issues while this is low is guaranteed to fit.
  assign stall      = free_slots < (PTR_W+1)'(3);
  assign space      = DEPTH_X - {1'b0, count} + {{(PTR_W+1){1'b0}}, pop};

  // Slot 2 first; accepted slots pack densely from tail, overflow drops the lowest slots.
  always_comb begin
    nwr   = '0;
    drop  = 1'b0;
    wr_en = '0;
    for (int k = 0; k < 3; k++) begin
      wr_ptr[k] = '0;
    end
    for (int k = 2; k >= 0; k--) begin
      if (acc[k]) begin
        if (nwr < space) begin
          wr_en[k]  = 1'b1;
          wr_ptr[k] = tail + nwr[PTR_W-1:0];
          nwr       = nwr + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr_en[k]) begin
          entries[wr_ptr[k]] <= issue_insts[k];
        end
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      tail  <= tail + nwr[PTR_W-1:0];
      count <= next_count(count, nwr, pop);
      if (drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fu_issue_fifo.sv
// Directed bench for fu_issue_fifo (ALU_1 instance, DEPTH=8).
module tb_fu_issue_fifo;
  import fu_issue_pkg::*;

  logic       clock;
  logic       reset;
  logic       squash;
  RS_S_PACKET issue_insts [2:0];
  logic       fu_ready;
  RS_S_PACKET fu_packet;
  logic       fu_valid;
  logic       stall;
  logic [3:0] count;
  logic       overflow_err;

  int checks;
  int failures;

  fu_issue_fifo #(.FU_TYPE(ALU_1), .DEPTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .squash(squash),
    .issue_insts(issue_insts),
    .fu_ready(fu_ready),
    .fu_packet(fu_packet),
    .fu_valid(fu_valid),
    .stall(stall),
    .count(count),
    .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic RS_S_PACKET mk(input logic v, input fu_sel_t sel, input logic [31:0] pc);
    RS_S_PACKET p;
    p         = '0;
    p.valid   = v;
    p.fu_sel  = sel;
    p.PC      = pc;
    p.inst    = pc ^ 32'hA5A5_0000;
    p.rob_idx = pc[6:2];
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < 3; k++) issue_insts[k] = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int popped;
  int pushed;
  logic [31:0] drain_pc [8];

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; squash = 1'b0; fu_ready = 1'b0;
    clr();
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(fu_valid), 64'd0);
    chk("rst_packet", 64'(fu_packet), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);

    // three-wide push, then ordered drain
    issue_insts[2] = mk(1, ALU_1, 32'h10);
    issue_insts[1] = mk(1, ALU_1, 32'h14);
    issue_insts[0] = mk(1, ALU_1, 32'h18);
    tick(); clr();
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_pc0", 64'(fu_packet.PC), 64'h10);
    chk("t1_stall", 64'(stall), 64'd0);
    chk("t1_valid", 64'(fu_valid), 64'd1);
    fu_ready = 1'b1;
    tick(); chk("t1_pc1", 64'(fu_packet.PC), 64'h14);
    tick(); chk("t1_pc2", 64'(fu_packet.PC), 64'h18);
    tick();
    chk("t1_empty_count", 64'(count), 64'd0);
    chk("t1_empty_packet", 64'(fu_packet), 64'd0);
    tick();
    chk("empty_no_underflow", 64'(count), 64'd0);
    fu_ready = 1'b0;

    // mixed FU classes, gap compression
    issue_insts[2] = mk(1, MULT_1, 32'h1C);
    issue_insts[1] = mk(1, ALU_1, 32'h20);
    issue_insts[0] = mk(1, ALU_1, 32'h24);
    tick(); clr();
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_pc0", 64'(fu_packet.PC), 64'h20);
    chk("t2_inst0", 64'(fu_packet.inst), 64'hA5A5_0020);
    fu_ready = 1'b1;
    tick();
    chk("t2_pc1", 64'(fu_packet.PC), 64'h24);
    chk("t2_count1", 64'(count), 64'd1);
    tick();
    chk("t2_count_end", 64'(count), 64'd0);
    fu_ready = 1'b0;

    // stall threshold and push into same-cycle freed space
    issue_insts[2] = mk(1, ALU_1, 32'h30);
    issue_insts[1] = mk(1, ALU_1, 32'h34);
    issue_insts[0] = mk(1, ALU_1, 32'h38);
    tick();
    issue_insts[2] = mk(1, ALU_1, 32'h3C);
    issue_insts[1] = mk(1, ALU_1, 32'h40);
    issue_insts[0] = mk(1, ALU_1, 32'h44);
    tick(); clr();
    chk("t3_count6", 64'(count), 64'd6);
    chk("t3_stall6", 64'(stall), 64'd1);
    fu_ready = 1'b1;
    tick();
    chk("t3_count5", 64'(count), 64'd5);
    chk("t3_stall5", 64'(stall), 64'd0);
    issue_insts[2] = mk(1, ALU_1, 32'h48);
    issue_insts[1] = mk(1, ALU_1, 32'h4C);
    issue_insts[0] = mk(1, ALU_1, 32'h50);
    tick(); clr();
    fu_ready = 1'b0;
    chk("t3_count7", 64'(count), 64'd7);
    chk("t3_ovf", 64'(overflow_err), 64'd0);
    chk("t3_head", 64'(fu_packet.PC), 64'h38);

    // full queue behaviour and overflow drops
    issue_insts[2] = mk(1, ALU_1, 32'h54);
    tick(); clr();
    chk("t4_full_count", 64'(count), 64'd8);
    chk("t4_full_stall", 64'(stall), 64'd1);
    chk("t4_full_valid", 64'(fu_valid), 64'd1);
    fu_ready = 1'b1;
    tick();
    fu_ready = 1'b0;
    chk("t4_pop_count", 64'(count), 64'd7);
    chk("t4_pop_stall", 64'(stall), 64'd1);
    issue_insts[2] = mk(1, ALU_1, 32'h58);
    issue_insts[1] = mk(1, ALU_1, 32'h5C);
    issue_insts[0] = mk(1, ALU_1, 32'h60);
    tick(); clr();
    chk("t4_partial_count", 64'(count), 64'd8);
    chk("t4_partial_ovf", 64'(overflow_err), 64'd1);
    issue_insts[2] = mk(1, ALU_1, 32'h64);
    issue_insts[1] = mk(1, ALU_1, 32'h68);
    tick(); clr();
    chk("t4_drop_count", 64'(count), 64'd8);
    drain_pc = '{32'h3C, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58};
    fu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_drain%0d", i), 64'(fu_packet.PC), 64'(drain_pc[i]));
      tick();
    end
    fu_ready = 1'b0;
    chk("t4_drained", 64'(count), 64'd0);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    chk("t4_ovf_sticky", 64'(overflow_err), 64'd1);

    // wrap-around with an RS that honours stall
    popped = 0; pushed = 0;
    for (int c = 0; c < 200 && popped < 20; c++) begin
      fu_ready = c[0];
      clr();
      if (!stall) begin
        for (int k = 2; k >= 0; k--) begin
          if (pushed < 20) begin
            issue_insts[k] = mk(1, ALU_1, 32'h100 + 32'(4 * pushed));
            pushed++;
          end
        end
      end
      if (fu_valid && fu_ready) begin
        chk($sformatf("t5_order%0d", popped), 64'(fu_packet.PC), 64'(32'h100 + 32'(4 * popped)));
        popped++;
      end
      tick();
    end
    clr();
    fu_ready = 1'b0;
    chk("t5_popped", 64'(popped), 64'd20);
    chk("t5_empty", 64'(count), 64'd0);

    // squash versus push, reset versus squash
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_rst_ovf", 64'(overflow_err), 64'd0);
    issue_insts[2] = mk(1, ALU_1, 32'h200);
    issue_insts[1] = mk(1, ALU_1, 32'h204);
    issue_insts[0] = mk(1, ALU_1, 32'h208);
    tick(); clr();
    issue_insts[2] = mk(1, ALU_1, 32'h20C);
    tick(); clr();
    chk("t6_count4", 64'(count), 64'd4);
    squash = 1'b1;
    issue_insts[2] = mk(1, ALU_1, 32'h210);
    issue_insts[1] = mk(1, ALU_1, 32'h214);
    issue_insts[0] = mk(1, ALU_1, 32'h218);
    tick(); clr();
    squash = 1'b0;
    chk("t6_sq_count", 64'(count), 64'd0);
    chk("t6_sq_valid", 64'(fu_valid), 64'd0);
    chk("t6_sq_packet", 64'(fu_packet), 64'd0);
    issue_insts[2] = mk(1, ALU_1, 32'h220);
    tick(); clr();
    chk("t6_after_sq_pc", 64'(fu_packet.PC), 64'h220);
    issue_insts[2] = mk(1, ALU_1, 32'h224);
    reset = 1'b1; squash = 1'b1;
    tick(); clr();
    reset = 1'b0; squash = 1'b0;
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_valid", 64'(fu_valid), 64'd0);
    chk("t6_rst_packet", 64'(fu_packet), 64'd0);
    chk("t6_rst_stall", 64'(stall), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
